// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 pixel path: colour layout, sequencer states, bit timing.
// Pure declarations; no logic and no latency of its own.
// No handshake of its own; the users of these constants define their own flow control.
package ws2812_pkg;

   // Pixel colour word layout {r, g, b}
   localparam int PIXEL_W = 24;
   localparam int R_HI    = 23;
   localparam int R_LO    = 16;
   localparam int G_HI    = 15;
   localparam int G_LO    = 8;
   localparam int B_HI    = 7;
   localparam int B_LO    = 0;

   // Bit timing in 20 ns clock ticks (50 MHz), shared with the ws2812 serial driver
   localparam int CLK_HZ      = 50_000_000;
   localparam int T0H_TICKS   = 20;    // 0.40 us
   localparam int T0L_TICKS   = 43;    // 0.85 us
   localparam int T1H_TICKS   = 40;    // 0.80 us
   localparam int T1L_TICKS   = 23;    // 0.45 us
   localparam int RESET_TICKS = 2500;  // 50 us latch low time

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_LATCH,
      ST_LATCH_LO,
      ST_LATCH_HI
   } seq_state_t;

endpackage

// File: rtl/ws_pixel_ram.sv
// Dual-bank simple-dual-port pixel RAM; the address MSB selects the bank.
// Latency: 1 cycle registered read; a same-address write returns the old data.
// No backpressure: one write and one read accepted every cycle.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data out (registered).
module ws_pixel_ram
   import ws2812_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [ADDR_W:0]    wr_addr,
   input  logic [PIXEL_W-1:0] wr_data,
   input  logic [ADDR_W:0]    rd_addr,
   output logic [PIXEL_W-1:0] rd_data
);

   logic [PIXEL_W-1:0] mem [0:(2**(ADDR_W+1))-1];

   // No reset on purpose: contents must survive rst and the array must map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Streams a double-buffered frame of 24-bit pixels into the ws2812 driver, then latches it.
// Latency: start in t -> first load in t+3 with ready high; 3 cycles of overhead per pixel.
// Backpressure: waits on ready in every handshake state; no timeout, so a stalled driver holds the frame.
// Ports: clk, rst (sync, active high); wr_en/wr_addr/wr_data write the back bank;
//        start/swap begin a frame; busy, frame_done status; r/g/b/load/ws_reset/ready driver side.
module ws2812_frame_sequencer
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 10,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [23:0]       wr_data,
   input  logic              start,
   input  logic              swap,
   output logic              busy,
   output logic              frame_done,
   output logic [7:0]        r,
   output logic [7:0]        g,
   output logic [7:0]        b,
   output logic              load,
   output logic              ws_reset,
   input  logic              ready
);

   localparam logic [ADDR_W:0]   NUM_LEDS_W = (ADDR_W+1)'(NUM_LEDS);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);

   seq_state_t         state, state_nxt;
   logic               bank_sel, bank_sel_nxt;
   logic [ADDR_W-1:0]  idx, idx_nxt;
   logic [PIXEL_W-1:0] pix, pix_nxt;
   logic [PIXEL_W-1:0] rd_data;
   logic               busy_nxt, done_nxt, load_nxt, ws_reset_nxt;
   logic               wr_ok;
   logic               last_px;

   // Out-of-range writes are dropped rather than aliased onto a real pixel.
   assign wr_ok   = wr_en && ({1'b0, wr_addr} < NUM_LEDS_W);
   assign last_px = (idx == LAST_IDX);

   // Host writes always land in the bank that is not being streamed.
   ws_pixel_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr ({~bank_sel, wr_addr}),
      .wr_data (wr_data),
      .rd_addr ({bank_sel, idx}),
      .rd_data (rd_data)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (start)  state_nxt = ST_FETCH;
         ST_FETCH:                state_nxt = ST_ISSUE;
         ST_ISSUE:    if (ready)  state_nxt = ST_WAIT_LO;
         ST_WAIT_LO:  if (!ready) state_nxt = ST_WAIT_HI;
         ST_WAIT_HI:  if (ready)  state_nxt = last_px ? ST_LATCH : ST_FETCH;
         ST_LATCH:    if (ready)  state_nxt = ST_LATCH_LO;
         ST_LATCH_LO: if (!ready) state_nxt = ST_LATCH_HI;
         ST_LATCH_HI: if (ready)  state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs and datapath
   always_comb begin
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      load_nxt     = 1'b0;
      ws_reset_nxt = 1'b0;
      idx_nxt      = idx;
      bank_sel_nxt = bank_sel;
      pix_nxt      = pix;
      case (state)
         ST_IDLE: begin
            if (start) begin
               busy_nxt = 1'b1;
               idx_nxt  = '0;
               if (swap) begin
                  bank_sel_nxt = ~bank_sel;
               end
            end
         end
         ST_ISSUE: begin
            // rd_data is valid here: the address was presented in FETCH.
            if (ready) begin
               load_nxt = 1'b1;
               pix_nxt  = rd_data;
            end
         end
         ST_WAIT_HI: begin
            if (ready && !last_px) begin
               idx_nxt = idx + ADDR_W'(1);
            end
         end
         ST_LATCH: begin
            if (ready) begin
               ws_reset_nxt = 1'b1;
            end
         end
         ST_LATCH_HI: begin
            if (ready) begin
               done_nxt = 1'b1;
               busy_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and datapath; RAM contents are deliberately left untouched by rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= 1'b0;
         frame_done <= 1'b0;
         load       <= 1'b0;
         ws_reset   <= 1'b0;
         idx        <= '0;
         bank_sel   <= 1'b0;
         pix        <= '0;
      end else begin
         busy       <= busy_nxt;
         frame_done <= done_nxt;
         load       <= load_nxt;
         ws_reset   <= ws_reset_nxt;
         idx        <= idx_nxt;
         bank_sel   <= bank_sel_nxt;
         pix        <= pix_nxt;
      end
   end

   assign r = pix[R_HI:R_LO];
   assign g = pix[G_HI:G_LO];
   assign b = pix[B_HI:B_LO];

endmodule

// File: doc/ws2812_frame_sequencer.md
# ws2812_frame_sequencer

Upstream stage for the `ws2812` serial driver. It holds a double-buffered frame of per-LED 24-bit colours and, on a start pulse, streams the frame pixel by pixel into the driver over its `load`/`ready` handshake. It then issues one `ws_reset` latch pulse and reports completion. It sits between the top-level pattern logic (the flash/pattern state machine in `mojo_top`) and `ws2812`, and replaces the ad-hoc LED-index loop in the top level.

## Interface
- `NUM_LEDS`, 10: LEDs in the strip, 1..2^ADDR_W.
- `ADDR_W`, 8: pixel address width.
- `clk` in 1: system clock (50 MHz on Mojo).
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write one pixel into the back bank this cycle.
- `wr_addr` in ADDR_W: pixel index; writes with `wr_addr >= NUM_LEDS` are dropped.
- `wr_data` in 24: colour as {r[23:16], g[15:8], b[7:0]}.
- `start` in 1: one-cycle request to send a frame.
- `swap` in 1: sampled with `start`; 1 = exchange front/back banks before sending.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse after the latch completes.
- `r`, `g`, `b` out 8 each: pixel colour to the driver, stable from `load` until the next `load`.
- `load` out 1: one-cycle pixel strobe to the driver.
- `ws_reset` out 1: one-cycle latch strobe to the driver.
- `ready` in 1: driver idle/accepting.

## Operation
- Two banks of NUM_LEDS×24 bits. `bank_sel` selects the front bank (read). Host writes always go to the back bank, including while streaming.
- States:
  - IDLE:
    - `start` → FETCH, with `idx`=0, `busy`=1.
    - If `swap`=1, `bank_sel` toggles in the same cycle.
    - `start` while not IDLE is ignored.
  - FETCH: present `idx` to the front bank; the read is registered, so data is valid next cycle. → ISSUE.
  - ISSUE: wait for `ready`=1. When it is seen, drive `r/g/b` from the read data, pulse `load`, → WAIT_LO.
  - WAIT_LO: wait for `ready`=0, the driver's acknowledgement. → WAIT_HI.
  - WAIT_HI: wait for `ready`=1.
    - If `idx` = NUM_LEDS-1 → LATCH.
    - Otherwise `idx`+1 → FETCH.
  - LATCH: wait for `ready`=1, pulse `ws_reset`, → LATCH_LO.
  - LATCH_LO: wait for `ready`=0. → LATCH_HI.
  - LATCH_HI: wait for `ready`=1, then pulse `frame_done`, clear `busy`, → IDLE.
- `load` and `ws_reset` are never high together. Neither is ever high for more than one cycle.
- `idx` is ADDR_W bits and never exceeds NUM_LEDS-1, so there is no wrap.
- A write to the same address and bank as a concurrent read returns the old data for the read.
- `rst` mid-frame:
  - All outputs are cleared and the state machine goes to IDLE.
  - `bank_sel` = 0.
  - RAM contents are not cleared.
  - `ws2812` shares `rst`, so no half-sent pixel is left pending.

## Timing
- Reset values: `busy`=0, `frame_done`=0, `load`=0, `ws_reset`=0, `r`=`g`=`b`=0.
- `start` in cycle t:
  - FETCH in t+1.
  - ISSUE in t+2.
  - Earliest `load` high in t+3, which requires `ready`=1 in t+2.
- Per pixel, overhead outside the driver's busy time is 3 cycles: ready seen → FETCH → ISSUE → load.
- `ready` is expected to fall exactly one cycle after `load`. WAIT_LO tolerates any delay.
- `frame_done` is high in the cycle after `ready`=1 is seen in LATCH_HI. `busy` falls in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `ws2812_pkg`:
  - colour field positions (R/G/B bit ranges);
  - state encoding for this block;
  - `RESET_TICKS` and bit-timing constants also used by `ws2812`.
- Sub-module `ws_pixel_ram`: dual-bank simple-dual-port RAM.
  - One write port, one registered read port.
  - Bank select is the RAM address MSB.
  - Infers block or distributed RAM.
- The sequencer FSM, `idx` counter and handshake all live in the top of this block.

## Test plan
- Write 0x3F3F3F to pixels 0..9 of the back bank; `start`+`swap` → exactly 10 `load` pulses, each with r=g=b=0x3F, then one `ws_reset`, then `frame_done` once; `busy` spans the whole sequence.
- Back-to-back frames:
  - Frame A (all 0x000000) and frame B (all 0xFF0000) alternated with `swap`=1 → driver-side capture alternates A, B, A.
  - A frame with `swap`=0 resends the previous front bank unchanged.
- Hold `ready`=0 for 500 cycles mid-frame → no `load` is issued. Resume → the next pixel index continues with no skip or duplicate.
- `start` pulsed during `busy`, and a write with `wr_addr`=NUM_LEDS → both ignored; the frame content and the `load` count (NUM_LEDS) are unchanged.
- Assert `rst` while in WAIT_LO on pixel 5 → next cycle all outputs are 0 and the state is IDLE. A subsequent `start` sends from pixel 0 of bank 0.
- NUM_LEDS=1: a single `load`, then `ws_reset`, then `frame_done`, with the first `load` at t+3 when `ready` is held high.
